// File: rtl/rv_pkg.sv
// Shared RV32IM pipeline definitions: opcodes, ALUOp/funct3 encodings,
// forwarding selects and the multiply/divide FSM state type.
`default_nettype none

package rv_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] F7_MDU = 7'b0000001;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mdu_state_e;

   // The reserved select value falls back to the register file.
   function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                           input logic [31:0] rf,
                                           input logic [31:0] mem,
                                           input logic [31:0] wb);
      case (sel)
         FWD_MEM: fwd_mux = mem;
         FWD_WB:  fwd_mux = wb;
         default: fwd_mux = rf;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_iter.sv
// Iterative RV32M unit: radix-2 shift-add multiplier and restoring divider
// on unsigned magnitudes, with sign fix-up applied when the result is read.
`default_nettype none

module mdu_iter
   import rv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic [2:0]  funct3_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o
);

   mdu_state_e  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] dvs_q, dvs_d;
   logic [2:0]  f3_q, f3_d;
   logic        neg_q, neg_d;
   logic        nega_q, nega_d;
   logic        divz_q, divz_d;

   logic        a_signed, b_signed, a_neg, b_neg;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum, div_sh, div_diff;
   logic [63:0] prod;
   logic [31:0] quot, rem;

   always_comb begin
      if (funct3_i[2]) begin
         a_signed = ~funct3_i[0];
         b_signed = ~funct3_i[0];
      end else begin
         a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU);
         b_signed = (funct3_i == F3_MULH);
      end
      a_neg = a_signed & op_a_i[31];
      b_neg = b_signed & op_b_i[31];
      mag_a = a_neg ? (32'd0 - op_a_i) : op_a_i;
      mag_b = b_neg ? (32'd0 - op_b_i) : op_b_i;
   end

   // acc_q holds {partial product, multiplier} or {remainder, quotient}.
   assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
   assign div_sh   = acc_q[63:31];
   assign div_diff = div_sh - {1'b0, dvs_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         acc_q   <= 64'd0;
         dvs_q   <= 32'd0;
         f3_q    <= 3'd0;
         neg_q   <= 1'b0;
         nega_q  <= 1'b0;
         divz_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         f3_q    <= f3_d;
         neg_q   <= neg_d;
         nega_q  <= nega_d;
         divz_q  <= divz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      f3_d    = f3_q;
      neg_d   = neg_q;
      nega_d  = nega_q;
      divz_d  = divz_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               busy_o  = 1'b1;
               state_d = RUN;
               cnt_d   = 6'd32;
               acc_d   = {32'd0, mag_a};
               dvs_d   = mag_b;
               f3_d    = funct3_i;
               neg_d   = a_neg ^ b_neg;
               nega_d  = a_neg;
               divz_d  = (op_b_i == 32'd0);
            end
         end
         RUN: begin
            busy_o = 1'b1;
            cnt_d  = cnt_q - 6'd1;
            if (f3_q[2]) begin
               if (!div_diff[32])
                  acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
               else
                  acc_d = {div_sh[31:0], acc_q[30:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
            end
            if (cnt_q == 6'd1)
               state_d = DONE;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Divide-by-zero yields all-ones quotient; the remainder path already
   // equals the dividend because every trial subtraction succeeds.
   always_comb begin
      prod     = neg_q ? (64'd0 - acc_q) : acc_q;
      quot     = divz_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
      rem      = nega_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
      if (f3_q[2])
         result_o = f3_q[1] ? rem : quot;
      else
         result_o = (f3_q == F3_MUL) ? prod[31:0] : prod[63:32];
   end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// RV32IM execute stage: operand forwarding, ALU, branch/jump resolution,
// iterative multiply/divide and the EX/MEM pipeline register.
`default_nettype none

module ex_stage
   import rv_pkg::*;
#(
   parameter bit          MDU_EN       = 1'b1,
   parameter logic [31:0] RESET_PC_OUT = 32'h0
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_in,
   input  logic [31:0] instruction_in,
   input  logic [31:0] reg1_in,
   input  logic [31:0] reg2_in,
   input  logic [31:0] imm_in,
   input  logic        RegWrite_in,
   input  logic        MemToReg_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        ALUSrc_in,
   input  logic        Branch_in,
   input  logic        Jump_in,
   input  logic [1:0]  ALUOp_in,
   input  logic [1:0]  fwd_a_sel,
   input  logic [1:0]  fwd_b_sel,
   input  logic [31:0] mem_fwd_data,
   input  logic [31:0] wb_fwd_data,
   output logic        ex_busy,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] pc_out,
   output logic [31:0] alu_result_out,
   output logic [31:0] store_data_out,
   output logic [4:0]  rd_out,
   output logic [2:0]  funct3_out,
   output logic        RegWrite_out,
   output logic        MemToReg_out,
   output logic        MemRead_out,
   output logic        MemWrite_out
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b;
   logic [4:0]  shamt;
   logic [31:0] alu_res, ex_result;
   logic        br_taken;
   logic        mdu_busy, mdu_done;
   logic [31:0] mdu_result;
   logic        unused_bits;

   logic [31:0] pc_q, alu_q, store_q;
   logic [4:0]  rd_q;
   logic [2:0]  funct3_q;
   logic        regwrite_q, memtoreg_q, memread_q, memwrite_q;

   assign opcode      = instruction_in[6:0];
   assign funct3      = instruction_in[14:12];
   assign funct7      = instruction_in[31:25];
   assign unused_bits = ^{instruction_in[24:15], funct7};

   assign rs1_fwd = fwd_mux(fwd_a_sel, reg1_in, mem_fwd_data, wb_fwd_data);
   assign rs2_fwd = fwd_mux(fwd_b_sel, reg2_in, mem_fwd_data, wb_fwd_data);

   always_comb begin
      op_a = rs1_fwd;
      if (ALUOp_in == ALUOP_ADD) begin
         if (opcode == OP_AUIPC)
            op_a = pc_in;
         else if (opcode == OP_LUI)
            op_a = 32'd0;
      end
   end

   assign op_b  = ALUSrc_in ? imm_in : rs2_fwd;
   assign shamt = op_b[4:0];

   always_comb begin
      alu_res = op_a + op_b;
      if ((ALUOp_in == ALUOP_RTYPE) || (ALUOp_in == ALUOP_ITYPE)) begin
         case (funct3)
            F3_ADD:  alu_res = (ALUOp_in == ALUOP_RTYPE && funct7[5]) ? (op_a - op_b)
                                                                      : (op_a + op_b);
            F3_SLL:  alu_res = op_a << shamt;
            F3_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            F3_SLTU: alu_res = {31'd0, op_a < op_b};
            F3_XOR:  alu_res = op_a ^ op_b;
            F3_SR:   alu_res = funct7[5] ? $unsigned($signed(op_a) >>> shamt)
                                         : (op_a >> shamt);
            F3_OR:   alu_res = op_a | op_b;
            default: alu_res = op_a & op_b;
         endcase
      end
   end

   always_comb begin
      case (funct3)
         F3_BEQ:  br_taken = (rs1_fwd == rs2_fwd);
         F3_BNE:  br_taken = (rs1_fwd != rs2_fwd);
         F3_BLT:  br_taken = $signed(rs1_fwd) < $signed(rs2_fwd);
         F3_BGE:  br_taken = $signed(rs1_fwd) >= $signed(rs2_fwd);
         F3_BLTU: br_taken = rs1_fwd < rs2_fwd;
         F3_BGEU: br_taken = rs1_fwd >= rs2_fwd;
         default: br_taken = 1'b0;
      endcase
   end

   // Bit 3 of the opcode separates JAL (1101111) from JALR (1100111).
   always_comb begin
      redirect_pc = pc_in + imm_in;
      if (Jump_in && !opcode[3])
         redirect_pc = (op_a + imm_in) & ~32'd1;
   end

   assign redirect = ~ex_busy & (Jump_in | (Branch_in & br_taken));

   generate
      if (MDU_EN) begin : g_mdu
         logic is_mdu;
         assign is_mdu = (ALUOp_in == ALUOP_RTYPE) && (funct7 == F7_MDU);

         // Gating with rst_n keeps ex_busy low while reset is held.
         mdu_iter u_mdu (
            .clk      (clk),
            .rst_n    (rst_n),
            .start_i  (is_mdu & rst_n),
            .op_a_i   (op_a),
            .op_b_i   (op_b),
            .funct3_i (funct3),
            .busy_o   (mdu_busy),
            .done_o   (mdu_done),
            .result_o (mdu_result)
         );
      end else begin : g_no_mdu
         assign mdu_busy   = 1'b0;
         assign mdu_done   = 1'b0;
         assign mdu_result = 32'd0;
      end
   endgenerate

   assign ex_busy   = mdu_busy;
   assign ex_result = Jump_in ? (pc_in + 32'd4) : (mdu_done ? mdu_result : alu_res);

   // While the MDU is busy the EX/MEM register receives a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC_OUT;
         alu_q      <= 32'd0;
         store_q    <= 32'd0;
         rd_q       <= 5'd0;
         funct3_q   <= 3'd0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
      end else if (ex_busy) begin
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
      end else begin
         pc_q       <= pc_in;
         alu_q      <= ex_result;
         store_q    <= rs2_fwd;
         rd_q       <= instruction_in[11:7];
         funct3_q   <= funct3;
         regwrite_q <= RegWrite_in & ~Branch_in;
         memtoreg_q <= MemToReg_in;
         memread_q  <= MemRead_in;
         memwrite_q <= MemWrite_in;
      end
   end

   assign pc_out         = pc_q;
   assign alu_result_out = alu_q;
   assign store_data_out = store_q;
   assign rd_out         = rd_q;
   assign funct3_out     = funct3_q;
   assign RegWrite_out   = regwrite_q;
   assign MemToReg_out   = memtoreg_q;
   assign MemRead_out    = memread_q;
   assign MemWrite_out   = memwrite_q;

endmodule

`default_nettype wire
